// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller driving one external full-adder cell.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, A, B, cin  request; operands and carry-in captured when accepted in IDLE
//   fa_x, fa_y, fa_z  to full adder: current A bit, current B bit, stored carry (0 outside RUN)
//   fa_s, fa_c        from full adder: sum and carry of the presented bits
//   busy, done        high during RUN; one-cycle pulse when the result lands
//   SUM, COUT         last completed result, held until the next addition completes
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             fa_x,
   output logic             fa_y,
   output logic             fa_z,
   input  logic             fa_s,
   input  logic             fa_c,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, s_q, sum_q, s_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, busy_q, done_q, last_d;
   // Returned sum bit enters at the MSB so the LSB-first stream lands in order;
   // written as shifts so WIDTH=1 needs no empty slice.
   assign s_d    = (s_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
   assign last_d = cnt_q == CW'(WIDTH - 1);
   assign fa_x   = busy_q & a_q[0];
   assign fa_y   = busy_q & b_q[0];
   assign fa_z   = busy_q & carry_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign SUM    = sum_q;
   assign COUT   = cout_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  s_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               s_q     <= s_d;
               carry_q <= fa_c;
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               // Holding at the last count keeps a 1-bit counter at 0 when WIDTH=1.
               cnt_q   <= last_d ? cnt_q : cnt_q + 1'b1;
               if (last_d) begin
                  sum_q   <= s_d;
                  cout_q  <= fa_c;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: three widths (8, 32, 1) against an arithmetic reference model.
module tb_serial_adder_ctrl;
   logic        clk = 0, rst = 0, start = 0, cin = 0;
   logic [31:0] A = 0, B = 0;
   logic [2:0]  fx, fy, fz, fs, fc, bz, dn, co;
   logic [7:0]  s8;
   logic [31:0] s32;
   logic        s1;
   always #5 clk = ~clk;
   // Ideal full-adder cells, one per instance
   assign fs = fx ^ fy ^ fz;
   assign fc = (fx & fy) | ((fx ^ fy) & fz);
   serial_adder_ctrl #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start), .A(A[7:0]), .B(B[7:0]), .cin(cin),
      .fa_x(fx[0]), .fa_y(fy[0]), .fa_z(fz[0]), .fa_s(fs[0]), .fa_c(fc[0]),
      .busy(bz[0]), .done(dn[0]), .SUM(s8), .COUT(co[0]));
   serial_adder_ctrl #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .cin(cin),
      .fa_x(fx[1]), .fa_y(fy[1]), .fa_z(fz[1]), .fa_s(fs[1]), .fa_c(fc[1]),
      .busy(bz[1]), .done(dn[1]), .SUM(s32), .COUT(co[1]));
   serial_adder_ctrl #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .start(start), .A(A[0:0]), .B(B[0:0]), .cin(cin),
      .fa_x(fx[2]), .fa_y(fy[2]), .fa_z(fz[2]), .fa_s(fs[2]), .fa_c(fc[2]),
      .busy(bz[2]), .done(dn[2]), .SUM(s1), .COUT(co[2]));
   localparam int W[3] = '{8, 32, 1};
   // Model: k=0 idle, k=1..W running on bit k-1, k=W+1 done
   int              k[3];
   longint unsigned ma[3], mb[3], mc[3], es[3], ec[3];
   int              total = 0, bad = 0, dcnt = 0, bcnt = 0;
   logic [7:0]      xrec, zrec;
   function automatic longint unsigned msk(input int w);
      return (64'd1 << w) - 1;
   endfunction
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         k[i] = 0; es[i] = 0; ec[i] = 0; ma[i] = 0; mb[i] = 0; mc[i] = 0;
      end
   endtask
   task automatic model_step();
      longint unsigned t;
      if (rst) model_reset();
      else for (int i = 0; i < 3; i++) begin
         if (k[i] == 0) begin
            if (start) begin
               ma[i] = longint'(A) & msk(W[i]);
               mb[i] = longint'(B) & msk(W[i]);
               mc[i] = longint'(cin);
               k[i] = 1;
            end
         end else if (k[i] <= W[i]) begin
            if (k[i] == W[i]) begin
               t = ma[i] + mb[i] + mc[i];
               es[i] = t & msk(W[i]);
               ec[i] = (t >> W[i]) & 1;
            end
            k[i]++;
         end else k[i] = 0;
      end
   endtask
   task automatic compare();
      longint unsigned ex, ey, ez, mj, sa;
      int j;
      for (int i = 0; i < 3; i++) begin
         ex = 0; ey = 0; ez = 0;
         if (k[i] >= 1 && k[i] <= W[i]) begin
            j = k[i] - 1;
            mj = msk(j);
            ex = (ma[i] >> j) & 1;
            ey = (mb[i] >> j) & 1;
            ez = (((ma[i] & mj) + (mb[i] & mj) + mc[i]) >> j) & 1;
         end
         sa = i == 0 ? {56'd0, s8} : i == 1 ? {32'd0, s32} : {63'd0, s1};
         chk($sformatf("busy%0d", i), {63'd0, bz[i]}, (k[i] >= 1 && k[i] <= W[i]) ? 1 : 0);
         chk($sformatf("done%0d", i), {63'd0, dn[i]}, k[i] == W[i] + 1 ? 1 : 0);
         chk($sformatf("fa_x%0d", i), {63'd0, fx[i]}, ex);
         chk($sformatf("fa_y%0d", i), {63'd0, fy[i]}, ey);
         chk($sformatf("fa_z%0d", i), {63'd0, fz[i]}, ez);
         chk($sformatf("sum%0d", i), sa, es[i]);
         chk($sformatf("cout%0d", i), {63'd0, co[i]}, ec[i]);
      end
   endtask
   // One cycle: check at the falling edge, step the model with the DUT at the rising edge
   task automatic cyc();
      @(negedge clk);
      compare();
      if (bz[0]) begin
         xrec = {fx[0], xrec[7:1]};
         zrec = {fz[0], zrec[7:1]};
         bcnt++;
      end
      if (dn[0]) dcnt++;
      @(posedge clk);
      model_step();
      #2;
   endtask
   task automatic go(input logic [31:0] a, input logic [31:0] b, input logic c);
      A = a; B = b; cin = c; start = 1;
      xrec = 0; zrec = 0; dcnt = 0; bcnt = 0;
      cyc();
      start = 0;
   endtask
   task automatic wait_idle();
      int n;
      n = 0;
      while ((bz != 0 || dn != 0) && n < 60) begin
         cyc();
         n++;
      end
      if (n >= 60) chk("idle_timeout", 1, 0);
      cyc();
   endtask
   initial begin
      #1 rst = 1;
      model_reset();
      cyc();
      cyc();
      rst = 0;
      cyc();
      chk("rst_sum", {56'd0, s8}, 0);
      chk("rst_busy", {61'd0, bz}, 0);
      go(32'h5A, 32'h33, 0);
      wait_idle();
      chk("5A_sum", {56'd0, s8}, 64'h8D);
      chk("5A_cout", {63'd0, co[0]}, 0);
      chk("5A_fa_x_seq", {56'd0, xrec}, 64'h5A);
      chk("5A_busy_cycles", bcnt, 8);
      chk("5A_done_pulses", dcnt, 1);
      chk("5A_sum32", {32'd0, s32}, 64'h8D);
      go(32'hFF, 32'h01, 0);
      wait_idle();
      chk("FF01_sum", {56'd0, s8}, 0);
      chk("FF01_cout", {63'd0, co[0]}, 1);
      chk("FF01_fa_z_seq", {56'd0, zrec}, 64'hFE);
      go(32'hFF, 32'hFF, 1);
      wait_idle();
      chk("FFFF_sum", {56'd0, s8}, 64'hFF);
      chk("FFFF_cout", {63'd0, co[0]}, 1);
      chk("w1_sum", {63'd0, s1}, 1);
      chk("w1_cout", {63'd0, co[2]}, 1);
      go(0, 0, 0);
      cyc(); cyc(); cyc();
      chk("hold_sum", {56'd0, s8}, 64'hFF);
      chk("hold_cout", {63'd0, co[0]}, 1);
      wait_idle();
      chk("zero_sum", {56'd0, s8}, 0);
      chk("zero_cout", {63'd0, co[0]}, 0);
      go(32'h0F, 32'h01, 0);
      cyc(); cyc();
      A = 32'h11; start = 1;
      cyc(); cyc();
      start = 0;
      wait_idle();
      chk("ign_sum", {56'd0, s8}, 64'h10);
      chk("ign_done_pulses", dcnt, 1);
      go(32'hAA, 32'h55, 0);
      cyc(); cyc(); cyc();
      rst = 1;
      model_reset();
      #1;
      chk("abort_busy", {63'd0, bz[0]}, 0);
      chk("abort_fa", {61'd0, fx[0], fy[0], fz[0]}, 0);
      chk("abort_sum", {56'd0, s8}, 0);
      cyc();
      rst = 0;
      cyc(); cyc();
      chk("abort_no_done", dcnt, 0);
      go(32'h01, 32'h02, 0);
      wait_idle();
      chk("after_abort_sum", {56'd0, s8}, 64'h03);
      for (int n = 0; n < 2000; n++) begin
         start = $urandom_range(0, 3) == 0;
         A = $urandom;
         B = $urandom;
         cin = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) begin
            A[7:0] = 8'hFF;
            B[7:0] = 8'h00;
            cin = 1;
         end
         cyc();
      end
      start = 0;
      wait_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
